// File: rtl/opl3_pkg.sv
// Shared types and default timing for the OPL3 host-side bus master.
package opl3_pkg;

    localparam int unsigned DEFAULT_SETUP_CYCLES   = 2;
    localparam int unsigned DEFAULT_STROBE_CYCLES  = 4;
    localparam int unsigned DEFAULT_GAP_CYCLES     = 24;
    localparam int unsigned DEFAULT_CMD_FIFO_DEPTH = 4;

    typedef struct packed {
        logic       is_read;
        logic       bank;
        logic [7:0] addr;
        logic [7:0] data;
    } host_cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_GAP,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_GAP,
        ST_R_SETUP,
        ST_R_STROBE,
        ST_R_GAP
    } bus_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/host_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module host_cmd_fifo
    import opl3_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_CMD_FIFO_DEPTH
) (
    input  logic      clk_host,
    input  logic      reset,
    input  logic      push,
    input  host_cmd_t wr_data,
    input  logic      pop,
    output host_cmd_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    host_cmd_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_host) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_host) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/opl3_bus_master.sv
// Queues host register writes / status reads and plays them onto the OPL3 bus
// with programmable setup, strobe and gap timing.
module opl3_bus_master
    import opl3_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = DEFAULT_SETUP_CYCLES,
    parameter int unsigned STROBE_CYCLES = DEFAULT_STROBE_CYCLES,
    parameter int unsigned GAP_CYCLES    = DEFAULT_GAP_CYCLES,
    parameter int unsigned FIFO_DEPTH    = DEFAULT_CMD_FIFO_DEPTH
) (
    input  logic       clk_host,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_read,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_status,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] address,
    output logic [7:0] bus_dout,
    input  logic [7:0] bus_din
);

    localparam int unsigned CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);

    host_cmd_t   fifo_wdata;
    host_cmd_t   fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    bus_state_t  state;
    bus_state_t  state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    logic        cur_bank;
    logic [7:0]  cur_addr;
    logic [7:0]  cur_data;

    assign fifo_wdata = '{is_read: req_is_read, bank: req_bank, addr: req_addr, data: req_data};
    assign req_ready  = !fifo_full;
    assign busy       = !fifo_empty || (state != ST_IDLE);

    host_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_host (clk_host),
        .reset    (reset),
        .push     (req_valid),
        .wr_data  (fifo_wdata),
        .pop      (pop),
        .rd_data  (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_host) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_bank <= 1'b0;
            cur_addr <= '0;
            cur_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) begin
                cur_bank <= fifo_rdata.bank;
                cur_addr <= fifo_rdata.addr;
                cur_data <= fifo_rdata.data;
            end
        end
    end

    // The counter reloads on every state change, from the length of the state being entered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = fifo_rdata.is_read ? ST_R_SETUP : ST_A_SETUP;
                end
            end
            ST_A_SETUP:  if (cnt == '0) state_n = ST_A_STROBE;
            ST_A_STROBE: if (cnt == '0) state_n = ST_A_GAP;
            ST_A_GAP:    if (cnt == '0) state_n = ST_D_SETUP;
            ST_D_SETUP:  if (cnt == '0) state_n = ST_D_STROBE;
            ST_D_STROBE: if (cnt == '0) state_n = ST_D_GAP;
            ST_D_GAP:    if (cnt == '0) state_n = ST_IDLE;
            ST_R_SETUP:  if (cnt == '0) state_n = ST_R_STROBE;
            ST_R_STROBE: if (cnt == '0) state_n = ST_R_GAP;
            ST_R_GAP:    if (cnt == '0) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase

        if (state_n != state) begin
            case (state_n)
                ST_A_SETUP, ST_D_SETUP, ST_R_SETUP:    cnt_n = SETUP_LD;
                ST_A_STROBE, ST_D_STROBE, ST_R_STROBE: cnt_n = STROBE_LD;
                ST_A_GAP, ST_D_GAP, ST_R_GAP:          cnt_n = GAP_LD;
                default:                               cnt_n = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
        end
    end

    // Bus pins follow the FSM state one cycle later, so nothing on req_* reaches a pin combinationally.
    always_ff @(posedge clk_host) begin
        if (reset) begin
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            address    <= '0;
            bus_dout   <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_A_SETUP, ST_A_STROBE: begin
                    address  <= {cur_bank, 1'b0};
                    bus_dout <= cur_addr;
                    wr_n     <= 1'b0;
                    rd_n     <= 1'b1;
                    cs_n     <= (state != ST_A_STROBE);
                end
                ST_D_SETUP, ST_D_STROBE: begin
                    address  <= {cur_bank, 1'b1};
                    bus_dout <= cur_data;
                    wr_n     <= 1'b0;
                    rd_n     <= 1'b1;
                    cs_n     <= (state != ST_D_STROBE);
                end
                ST_R_SETUP, ST_R_STROBE: begin
                    address  <= 2'b00;
                    bus_dout <= '0;
                    wr_n     <= 1'b1;
                    rd_n     <= 1'b0;
                    cs_n     <= (state != ST_R_STROBE);
                end
                default: begin
                    cs_n <= 1'b1;
                    rd_n <= 1'b1;
                    wr_n <= 1'b1;
                end
            endcase
            if (state == ST_R_GAP && cnt == '0) begin
                rsp_valid  <= 1'b1;
                rsp_status <= bus_din;
            end
        end
    end

endmodule

// File: tb/tb_opl3_bus_master.sv
// Directed bench for opl3_bus_master with a small OPL3 host-interface model on the bus side.
module tb_opl3_bus_master;

    logic       clk_host = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_is_read;
    logic       req_bank;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_status;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] address;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;

    logic [7:0] model_status = 8'h00;
    assign bus_din = model_status;

    always #5 clk_host = ~clk_host;

    opl3_bus_master #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (4),
        .GAP_CYCLES    (24),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk_host   (clk_host),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_is_read(req_is_read),
        .req_bank   (req_bank),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .busy       (busy),
        .cs_n       (cs_n),
        .rd_n       (rd_n),
        .wr_n       (wr_n),
        .address    (address),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din)
    );

    // Host-interface model: latches the register address on the A strobe, writes on the D strobe.
    logic [7:0]  opl3_reg [2][256];
    logic [7:0]  lat_addr = 8'h00;
    logic [16:0] wr_log [$];
    logic        prev_cs = 1'b1;
    logic        clr_gap = 1'b0;
    logic        seen_strobe = 1'b0;
    int          gap_run = 0;
    int          min_gap = 1000;

    always @(negedge clk_host) begin
        if (clr_gap) begin
            min_gap     = 1000;
            seen_strobe = 1'b0;
        end
        if (reset) begin
            prev_cs     = 1'b1;
            seen_strobe = 1'b0;
            gap_run     = 0;
        end else begin
            if (prev_cs && !cs_n) begin
                if (seen_strobe && gap_run < min_gap) min_gap = gap_run;
                seen_strobe = 1'b1;
                if (!wr_n) begin
                    if (!address[0]) begin
                        lat_addr = bus_dout;
                    end else begin
                        opl3_reg[address[1]][lat_addr] = bus_dout;
                        wr_log.push_back({address[1], lat_addr, bus_dout});
                    end
                end
            end
            gap_run = cs_n ? gap_run + 1 : 0;
            prev_cs = cs_n;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_host);
        #1;
    endtask

    task automatic set_req(input logic is_rd, input logic bank, input logic [7:0] a,
                           input logic [7:0] d);
        req_is_read = is_rd;
        req_bank    = bank;
        req_addr    = a;
        req_data    = d;
    endtask

    logic [16:0] exp_w [5];

    initial begin
        int first_fall, d_fall, cs_low, busy_low_t;
        int rd_low, wr_low, rsp_cnt, rsp_t, ready_low, k, tt, log_base, rsp_cnt2;
        logic [1:0] a_addr, d_addr;
        logic [7:0] a_dout, d_dout, rsp_seen;
        logic rdy, rd_addr_bad;

        exp_w[0] = {1'b0, 8'h20, 8'h01};
        exp_w[1] = {1'b1, 8'hB0, 8'h32};
        exp_w[2] = {1'b0, 8'hA0, 8'h98};
        exp_w[3] = {1'b1, 8'h40, 8'h3F};
        exp_w[4] = {1'b0, 8'hBD, 8'h00};

        reset     = 1'b1;
        req_valid = 1'b0;
        set_req(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_address", address, 0);
        check("rst_bus_dout", bus_dout, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();
        check("rst_req_ready", req_ready, 1);

        // Single write: bank 1, reg 0xBD <- 0x20; t counts cycles after the accepting edge.
        set_req(1'b0, 1'b1, 8'hBD, 8'h20);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("wr_busy_on_accept", busy, 1);
        first_fall = -1; d_fall = -1; cs_low = 0; busy_low_t = -1;
        a_addr = '0; d_addr = '0; a_dout = '0; d_dout = '0;
        for (int t = 1; t <= 80; t++) begin
            step();
            if (!cs_n) begin
                cs_low++;
                if (first_fall < 0) begin
                    first_fall = t; a_addr = address; a_dout = bus_dout;
                end else if (t > first_fall + 4 && d_fall < 0) begin
                    d_fall = t; d_addr = address; d_dout = bus_dout;
                end
            end
            if (!busy && busy_low_t < 0) busy_low_t = t;
        end
        check("wr_first_cs_fall", first_fall, 4);
        check("wr_a_address", a_addr, 2'b10);
        check("wr_a_dout", a_dout, 8'hBD);
        check("wr_d_cs_fall", d_fall, 34);
        check("wr_d_address", d_addr, 2'b11);
        check("wr_d_dout", d_dout, 8'h20);
        check("wr_cs_low_total", cs_low, 8);
        check("wr_busy_drop", busy_low_t, 61);
        check("wr_model_reg", opl3_reg[1][8'hBD], 8'h20);

        // Status read returning 0x60.
        model_status = 8'h60;
        set_req(1'b1, 1'b0, 8'h00, 8'h00);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        rd_low = 0; wr_low = 0; cs_low = 0; rsp_cnt = 0; rsp_t = -1;
        rsp_seen = '0; rd_addr_bad = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (!rd_n) begin
                rd_low++;
                if (address != 2'b00) rd_addr_bad = 1'b1;
            end
            if (!wr_n) wr_low++;
            if (!cs_n) cs_low++;
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_t < 0) begin rsp_t = t; rsp_seen = rsp_status; end
            end
        end
        check("rd_rd_n_low", rd_low, 6);
        check("rd_wr_n_low", wr_low, 0);
        check("rd_cs_low", cs_low, 4);
        check("rd_address", rd_addr_bad, 0);
        check("rd_rsp_count", rsp_cnt, 1);
        check("rd_rsp_time", rsp_t, 31);
        check("rd_rsp_status", rsp_seen, 8'h60);
        check("rd_busy_end", busy, 0);
        model_status = 8'h00;

        // Five back-to-back writes through a depth-4 FIFO (pointers wrap).
        clr_gap = 1'b1;
        step();
        clr_gap = 1'b0;
        log_base = wr_log.size();
        k = 0; tt = 0;
        while (k < 5 && tt < 20) begin
            set_req(1'b0, exp_w[k][16], exp_w[k][15:8], exp_w[k][7:0]);
            req_valid = 1'b1;
            rdy = req_ready;
            step();
            tt++;
            if (rdy) k++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", k, 5);
        check("b2b_accept_cycles", tt, 5);
        check("b2b_ready_full", req_ready, 0);
        ready_low = 0; busy_low_t = -1; rsp_cnt2 = 0;
        for (int t = 5; t <= 400 && busy_low_t < 0; t++) begin
            step();
            if (!req_ready) ready_low++;
            if (rsp_valid) rsp_cnt2++;
            if (!busy) busy_low_t = t;
        end
        check("b2b_ready_low_cycles", ready_low, 57);
        check("b2b_busy_drop", busy_low_t, 305);
        check("b2b_log_count", wr_log.size() - log_base, 5);
        for (int i = 0; i < 5; i++) begin
            if (log_base + i < wr_log.size())
                check($sformatf("b2b_order_%0d", i), wr_log[log_base + i], exp_w[i]);
            else
                check($sformatf("b2b_order_%0d", i), 17'h1FFFF, exp_w[i]);
        end
        check("b2b_min_cs_gap", min_gap, 26);
        check("b2b_no_rsp", rsp_cnt2, 0);
        check("rsp_status_hold", rsp_status, 8'h60);

        // Reset during the second D-strobe cycle with a read and a write still queued.
        set_req(1'b0, 1'b0, 8'h11, 8'h22);
        req_valid = 1'b1;
        step();
        set_req(1'b1, 1'b0, 8'h00, 8'h00);
        step();
        set_req(1'b0, 1'b1, 8'h33, 8'h44);
        step();
        req_valid = 1'b0;
        for (int t = 3; t <= 35; t++) step();
        check("rst_mid_cs_low", cs_n, 0);
        check("rst_mid_wr_low", wr_n, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_wr_n", wr_n, 1);
        check("rst_mid_rd_n", rd_n, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_rsp", rsp_valid, 0);
        cs_low = 0; rsp_cnt = 0; busy_low_t = 0;
        for (int t = 0; t < 100; t++) begin
            step();
            if (!cs_n || !rd_n || !wr_n) cs_low++;
            if (rsp_valid) rsp_cnt++;
            if (busy) busy_low_t++;
        end
        check("rst_post_bus_idle", cs_low, 0);
        check("rst_post_no_rsp", rsp_cnt, 0);
        check("rst_post_not_busy", busy_low_t, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
